// File: rtl/generic_bus_arbiter.sv
// Two-requester arbiter sharing one generic bus slave between instruction fetch (I) and data (D).
// Define GENERIC_BUS_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise D has fixed priority.
module generic_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_ren,
  input  logic                    i_wen,
  input  logic [DATA_WIDTH/8-1:0] i_byte_en,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_busy,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic                    d_ren,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH/8-1:0] d_byte_en,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_busy,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic                    m_ren,
  output logic                    m_wen,
  output logic [DATA_WIDTH/8-1:0] m_byte_en,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state, next_state;
  logic   i_pend, d_pend, choose_d;

  assign i_pend = i_ren | i_wen;
  assign d_pend = d_ren | d_wen;

`ifdef GENERIC_BUS_ARB_ROUND_ROBIN_EN
  // last_grant_d low means I was granted most recently; the other side wins the next conflict.
  logic last_grant_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && next_state != IDLE) begin
      last_grant_d <= (next_state == GRANT_D);
    end
  end

  assign choose_d = d_pend & (~i_pend | ~last_grant_d);
`else
  assign choose_d = d_pend;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A grant always falls back to IDLE on completion or abandon, leaving one bubble cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (choose_d) begin
          next_state = GRANT_D;
        end else if (i_pend) begin
          next_state = GRANT_I;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT_I: begin
        if (!i_pend || !m_busy) begin
          next_state = IDLE;
        end
      end
      GRANT_D: begin
        if (!d_pend || !m_busy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_addr    = '0;
    m_wdata   = '0;
    m_ren     = 1'b0;
    m_wen     = 1'b0;
    m_byte_en = '0;
    i_busy    = 1'b1;
    d_busy    = 1'b1;
    case (state)
      GRANT_I: begin
        m_addr    = i_addr;
        m_wdata   = i_wdata;
        m_ren     = i_ren;
        m_wen     = i_wen;
        m_byte_en = i_byte_en;
        i_busy    = m_busy;
      end
      GRANT_D: begin
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        m_ren     = d_ren;
        m_wen     = d_wen;
        m_byte_en = d_byte_en;
        d_busy    = m_busy;
      end
      default: begin
        m_ren = 1'b0;
      end
    endcase
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Scoreboard testbench for generic_bus_arbiter: expected outputs are queued as stimulus is
// driven and compared once per cycle, mid-cycle, against the DUT.
module tb_generic_bus_arbiter;

  typedef struct packed {
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byte_en;
    logic        i_busy;
    logic        d_busy;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } obs_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  i_byte_en, d_byte_en, m_byte_en;
  logic        i_ren, i_wen, i_busy, d_ren, d_wen, d_busy, m_ren, m_wen, m_busy;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  generic_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(clk), .nRST(n_rst),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_ren(i_ren), .i_wen(i_wen), .i_byte_en(i_byte_en),
    .i_rdata(i_rdata), .i_busy(i_busy),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ren(d_ren), .d_wen(d_wen), .d_byte_en(d_byte_en),
    .d_rdata(d_rdata), .d_busy(d_busy),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ren(m_ren), .m_wen(m_wen), .m_byte_en(m_byte_en),
    .m_rdata(m_rdata), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.m_ren = m_ren; o.m_wen = m_wen; o.m_addr = m_addr; o.m_wdata = m_wdata;
    o.m_byte_en = m_byte_en; o.i_busy = i_busy; o.d_busy = d_busy;
    o.i_rdata = i_rdata; o.d_rdata = d_rdata;
    return o;
  endfunction

  function automatic obs_t exp_idle(logic [31:0] rd);
    obs_t e;
    e = '0;
    e.i_busy = 1'b1; e.d_busy = 1'b1; e.i_rdata = rd; e.d_rdata = rd;
    return e;
  endfunction

  function automatic obs_t exp_grant(logic is_d, logic ren, logic wen, logic [31:0] addr,
                                     logic [31:0] wdata, logic [3:0] be, logic busy,
                                     logic [31:0] rd);
    obs_t e;
    e = exp_idle(rd);
    e.m_ren = ren; e.m_wen = wen; e.m_addr = addr; e.m_wdata = wdata; e.m_byte_en = be;
    if (is_d) e.d_busy = busy;
    else e.i_busy = busy;
    return e;
  endfunction

  task automatic clear_requests();
    i_addr = '0; i_wdata = '0; i_ren = 0; i_wen = 0; i_byte_en = '0;
    d_addr = '0; d_wdata = '0; d_ren = 0; d_wen = 0; d_byte_en = '0;
  endtask

  task automatic test_reset();
    obs_t got, expv;
    string nm;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_rst = (c == 3);
      if (c == 3) clear_requests();
      else begin
        i_ren = 1; i_addr = 32'h40; d_wen = 1; d_addr = 32'h80; d_wdata = 32'h55; d_byte_en = 4'hF;
      end
      m_rdata = 32'hC0DE_0000 + c; m_busy = 0;
      exp_q.push_back(exp_idle(m_rdata)); name_q.push_back($sformatf("reset c%0d", c));
      #5;
      got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
      end
    end
  endtask

  task automatic test_contention();
    obs_t got, expv;
    string nm;
    logic win_d;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        i_ren = 1; i_addr = 32'h100; d_ren = 1; d_addr = 32'h200;
      end else clear_requests();
      m_busy = 0; m_rdata = 32'hA5A5_0000 + c;
`ifdef GENERIC_BUS_ARB_ROUND_ROBIN_EN
      win_d = (((c - 1) / 2) % 2) == 0;
`else
      win_d = 1'b1;
`endif
      if (c % 2 == 1)
        exp_q.push_back(exp_grant(win_d, 1'b1, 1'b0, win_d ? 32'h200 : 32'h100, 32'h0, 4'h0,
                                  1'b0, m_rdata));
      else
        exp_q.push_back(exp_idle(m_rdata));
      name_q.push_back($sformatf("contention c%0d", c));
      #5;
      got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
      end
    end
  endtask

  task automatic test_i_read();
    obs_t got, expv;
    string nm;
    for (int c = 0; c <= 2; c++) begin
      @(posedge clk); #1;
      if (c < 2) begin
        i_ren = 1; i_addr = 32'h100;
      end else clear_requests();
      m_busy = 0; m_rdata = 32'hDEAD_BEEF;
      if (c == 1) exp_q.push_back(exp_grant(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, m_rdata));
      else exp_q.push_back(exp_idle(m_rdata));
      name_q.push_back($sformatf("i_read c%0d", c));
      #5;
      got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
      end
    end
  endtask

  task automatic test_d_write_wait();
    obs_t got, expv;
    string nm;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c < 5) begin
        d_wen = 1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_byte_en = 4'b0011;
      end else clear_requests();
      m_busy = (c < 4); m_rdata = 32'h0BAD_0000 + c;
      if (c >= 1 && c <= 4)
        exp_q.push_back(exp_grant(1'b1, 1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'b0011,
                                  (c < 4), m_rdata));
      else exp_q.push_back(exp_idle(m_rdata));
      name_q.push_back($sformatf("d_write_wait c%0d", c));
      #5;
      got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
      end
    end
  endtask

  task automatic test_abandon();
    obs_t got, expv;
    string nm;
    for (int c = 0; c <= 3; c++) begin
      @(posedge clk); #1;
      i_addr = 32'h100; i_ren = (c < 2);
      m_busy = 1; m_rdata = 32'h7777_0000 + c;
      if (c == 1 || c == 2)
        exp_q.push_back(exp_grant(1'b0, (c == 1), 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, m_rdata));
      else exp_q.push_back(exp_idle(m_rdata));
      name_q.push_back($sformatf("abandon c%0d", c));
      #5;
      got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
      end
    end
    clear_requests();
  endtask

  task automatic test_reset_mid_transfer();
    obs_t got, expv;
    string nm;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 2) n_rst = 1;
      if (c < 2) begin
        d_ren = 1; d_addr = 32'h300;
      end
      if (c == 4) clear_requests();
      m_busy = (c < 2); m_rdata = 32'h3333_0000 + c;
      if (c == 1) exp_q.push_back(exp_grant(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1, m_rdata));
      else if (c == 3) exp_q.push_back(exp_grant(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0, m_rdata));
      else exp_q.push_back(exp_idle(m_rdata));
      name_q.push_back($sformatf("reset_mid c%0d", c));
      #5;
      got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
      end
      if (c == 1) begin
        #1;
        n_rst = 0; d_ren = 0; d_addr = '0; i_ren = 1; i_addr = 32'h104;
        exp_q.push_back(exp_idle(m_rdata)); name_q.push_back("reset_mid async");
        #1;
        got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
        if (got !== expv) begin
          errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
        end
      end
    end
  endtask

  task automatic test_idle_bus();
    obs_t got, expv;
    string nm;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      clear_requests();
      m_busy = 1'($urandom_range(0, 1)); m_rdata = $urandom;
      exp_q.push_back(exp_idle(m_rdata)); name_q.push_back($sformatf("idle c%0d", c));
      #5;
      got = observe(); expv = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("[TB] FAIL %s: got=%h required=%h", nm, got, expv);
      end
    end
  endtask

  initial begin
    clear_requests();
    m_busy = 0; m_rdata = '0;
    test_reset();
    test_contention();
    test_i_read();
    test_d_write_wait();
    test_abandon();
    test_reset_mid_transfer();
    test_idle_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
